// File: rtl/ascii_tolower_stream.sv
// ascii_tolower_stream: valid/ready byte stream lower-caser with 2-entry skid buffer and per-string changed-letter count
module ascii_tolower_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [9:0] head, skid, in_ent;
  logic [CNT_W-1:0] run, run_inc;
  logic upper, acc, pop;
  assign upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign in_ent = {upper, in_data == 8'h00, upper ? (in_data | 8'h20) : in_data};
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign run_inc = (&run) ? run : run + CNT_W'(head[9]);
  always_comb begin
    state_n = state == EMPTY ? (acc ? ONE : EMPTY) :
              state == ONE   ? (acc & !pop ? TWO : !acc & pop ? EMPTY : ONE) :
                               (pop ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      head      <= '0;
      skid      <= '0;
      run       <= '0;
      cnt       <= '0;
      cnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= state_n != TWO;
      cnt_valid <= pop & head[8];
      if (state == TWO && pop)
        head <= skid;
      else if (acc && (state == EMPTY || pop))
        head <= in_ent;
      if (acc && state == ONE && !pop)
        skid <= in_ent;
      if (pop && head[8]) begin
        cnt <= run_inc;
        run <= '0;
      end else if (pop) begin
        run <= run_inc;
      end
    end
  end
  always_comb begin
    out_valid = state != EMPTY;
    out_data  = head[7:0];
    out_last  = head[8];
  end
endmodule
